// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants and helpers for the raster generator and renderers.
package vga_timing_gen_pkg;

   typedef struct packed {
      int   h_active;
      int   h_fp;
      int   h_sync;
      int   h_bp;
      int   v_active;
      int   v_fp;
      int   v_sync;
      int   v_bp;
      logic hs_pol;
      logic vs_pol;
   } vga_mode_t;

   // 640x480@60, 25.175 MHz pixel clock, negative syncs
   localparam vga_mode_t VGA_640X480 = '{
      h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
      hs_pol:   1'b0, vs_pol: 1'b0
   };

   // 800x600@60, 40 MHz pixel clock, positive syncs
   localparam vga_mode_t SVGA_800X600 = '{
      h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
      v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
      hs_pol:   1'b1, vs_pol: 1'b1
   };

   function automatic int axis_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic bit axis_legal(input int active, input int fp,
                                     input int sync, input int bp);
      return (active >= 1) && (fp >= 1) && (sync >= 1) && (bp >= 1);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and active
// flags decoded from the next count, so flags always match Count.
module vga_axis_counter
   import vga_timing_gen_pkg::*;
#(
   parameter int   ACTIVE = 640,
   parameter int   FP     = 16,
   parameter int   SYNC   = 96,
   parameter int   BP     = 48,
   parameter logic POL    = 1'b0,
   parameter int   W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Advance,
   output logic [W-1:0] Count,
   output logic         Sync,
   output logic         InActive,
   output logic         Wrap
);

   localparam int            TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [W-1:0]  LAST       = W'(TOTAL - 1);
   localparam logic [W-1:0]  SYNC_FIRST = W'(ACTIVE + FP);
   localparam logic [W-1:0]  SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);
   localparam logic [W-1:0]  ACT_END    = W'(ACTIVE);

   logic [W-1:0] count_q, count_d;
   logic         sync_q, sync_d;
   logic         act_q, act_d;

   always_comb begin
      Wrap    = Advance && (count_q == LAST);
      count_d = count_q;
      if (Wrap) begin
         count_d = '0;
      end else if (Advance) begin
         count_d = count_q + 1'b1;
      end
      sync_d = ((count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST)) ? POL : ~POL;
      act_d  = (count_d < ACT_END);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count_q <= '0;
         sync_q  <= ~POL;
         act_q   <= 1'b1;
      end else begin
         count_q <= count_d;
         sync_q  <= sync_d;
         act_q   <= act_d;
      end
   end

   assign Count    = count_q;
   assign Sync     = sync_q;
   assign InActive = act_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock divider feeding X/Y axis counters,
// with sync, active-video and line/frame markers aligned to CounterX/CounterY.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int   H_ACTIVE = VGA_640X480.h_active,
   parameter int   H_FP     = VGA_640X480.h_fp,
   parameter int   H_SYNC   = VGA_640X480.h_sync,
   parameter int   H_BP     = VGA_640X480.h_bp,
   parameter int   V_ACTIVE = VGA_640X480.v_active,
   parameter int   V_FP     = VGA_640X480.v_fp,
   parameter int   V_SYNC   = VGA_640X480.v_sync,
   parameter int   V_BP     = VGA_640X480.v_bp,
   parameter logic HS_POL   = VGA_640X480.hs_pol,
   parameter logic VS_POL   = VGA_640X480.vs_pol,
   parameter int   CLK_DIV  = 1,
   localparam int  XW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   localparam int  YW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic          Clk,
   input  logic          Reset,
   output logic [XW-1:0] CounterX,
   output logic [YW-1:0] CounterY,
   output logic          Hsync,
   output logic          Vsync,
   output logic          Active,
   output logic          PixelTick,
   output logic          LineStart,
   output logic          FrameStart
);

   if (!(axis_legal(H_ACTIVE, H_FP, H_SYNC, H_BP) &&
         axis_legal(V_ACTIVE, V_FP, V_SYNC, V_BP) && (CLK_DIV >= 1))) begin : g_bad_params
      $error("vga_timing_gen: illegal timing parameters");
   end

   localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic          tick_q, tick_d;
   logic          line_q, line_d;
   logic          frame_q, frame_d;
   logic          advance;
   logic          x_wrap, y_wrap;
   logic          x_act, y_act;

   // Markers use the wrap strobes: when the divider returns to 0 the X counter
   // has just advanced, so next-X==0 is exactly an X wrap this edge.
   always_comb begin
      advance = (div_q == DIV_LAST);
      div_d   = advance ? '0 : div_q + 1'b1;
      tick_d  = advance;
      line_d  = x_wrap;
      frame_d = x_wrap && y_wrap;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         div_q   <= '0;
         tick_q  <= 1'b1;
         line_q  <= 1'b1;
         frame_q <= 1'b1;
      end else begin
         div_q   <= div_d;
         tick_q  <= tick_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HS_POL),
      .W      (XW)
   ) u_x (
      .Clk      (Clk),
      .Reset    (Reset),
      .Advance  (advance),
      .Count    (CounterX),
      .Sync     (Hsync),
      .InActive (x_act),
      .Wrap     (x_wrap)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VS_POL),
      .W      (YW)
   ) u_y (
      .Clk      (Clk),
      .Reset    (Reset),
      .Advance  (x_wrap),
      .Count    (CounterY),
      .Sync     (Vsync),
      .InActive (y_act),
      .Wrap     (y_wrap)
   );

   assign Active     = x_act && y_act;
   assign PixelTick  = tick_q;
   assign LineStart  = line_q;
   assign FrameStart = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a tiny 8/1/2/1 x 4/1/1/1 mode
// at CLK_DIV 1 and 2, checked cycle by cycle against a cycle-index model.
module tb_vga_timing_gen;

   logic Clk;
   logic Reset;

   logic [9:0] d_x, d_y;
   logic       d_hs, d_vs, d_act, d_tick, d_ls, d_fs;
   logic [3:0] a_x, b_x;
   logic [2:0] a_y, b_y;
   logic       a_hs, a_vs, a_act, a_tick, a_ls, a_fs;
   logic       b_hs, b_vs, b_act, b_tick, b_ls, b_fs;

   int n_checks = 0;
   int n_fail   = 0;

   vga_timing_gen u_def (
      .Clk(Clk), .Reset(Reset), .CounterX(d_x), .CounterY(d_y),
      .Hsync(d_hs), .Vsync(d_vs), .Active(d_act), .PixelTick(d_tick),
      .LineStart(d_ls), .FrameStart(d_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)
   ) u_sm1 (
      .Clk(Clk), .Reset(Reset), .CounterX(a_x), .CounterY(a_y),
      .Hsync(a_hs), .Vsync(a_vs), .Active(a_act), .PixelTick(a_tick),
      .LineStart(a_ls), .FrameStart(a_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2)
   ) u_sm2 (
      .Clk(Clk), .Reset(Reset), .CounterX(b_x), .CounterY(b_y),
      .Hsync(b_hs), .Vsync(b_vs), .Active(b_act), .PixelTick(b_tick),
      .LineStart(b_ls), .FrameStart(b_fs)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Expected outputs of the default instance 'cyc' clocks after reset release.
   function automatic logic [31:0] exp_def(input int cyc);
      int   x;
      int   y;
      logic hs, vs, act;
      x   = cyc % 800;
      y   = (cyc / 800) % 525;
      hs  = !(x >= 656 && x <= 751);
      vs  = !(y >= 490 && y <= 491);
      act = (x < 640) && (y < 480);
      return {6'd0, 10'(x), 10'(y), hs, vs, act, 1'b1, (x == 0), (x == 0 && y == 0)};
   endfunction

   // Expected outputs of the 12x7 mode with divider 'div' and polarity 'pol'.
   function automatic logic [31:0] exp_small(input int cyc, input int div, input logic pol);
      int   pix, x, y;
      logic tick, hs, vs, act;
      pix  = cyc / div;
      tick = ((cyc % div) == 0);
      x    = pix % 12;
      y    = (pix / 12) % 7;
      hs   = (x >= 9 && x <= 10) ? pol : !pol;
      vs   = (y == 5) ? pol : !pol;
      act  = (x < 8) && (y < 4);
      return {19'd0, 4'(x), 3'(y), hs, vs, act, tick, tick && (x == 0), tick && (x == 0) && (y == 0)};
   endfunction

   function automatic logic [31:0] obs_def();
      return {6'd0, d_x, d_y, d_hs, d_vs, d_act, d_tick, d_ls, d_fs};
   endfunction

   function automatic logic [31:0] obs_a();
      return {19'd0, a_x, a_y, a_hs, a_vs, a_act, a_tick, a_ls, a_fs};
   endfunction

   function automatic logic [31:0] obs_b();
      return {19'd0, b_x, b_y, b_hs, b_vs, b_act, b_tick, b_ls, b_fs};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag, input int cyc);
      check($sformatf("%s_def@%0d", tag, cyc), obs_def(), exp_def(cyc));
      check($sformatf("%s_div1@%0d", tag, cyc), obs_a(), exp_small(cyc, 1, 1'b1));
      check($sformatf("%s_div2@%0d", tag, cyc), obs_b(), exp_small(cyc, 2, 1'b0));
   endtask

   int hs_low_line0;
   int act_two_lines;
   int def_line_starts;
   int a_vs_frame0;
   int a_frames, b_frames, b_ticks;
   int a_last_fs, b_last_fs;

   initial begin
      hs_low_line0    = 0;
      act_two_lines   = 0;
      def_line_starts = 0;
      a_vs_frame0     = 0;
      a_frames        = 0;
      b_frames        = 0;
      b_ticks         = 0;
      a_last_fs       = -1;
      b_last_fs       = -1;

      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      check_all("reset", 0);

      Reset = 1'b0;
      #1;
      for (int cyc = 0; cyc < 1901; cyc++) begin
         check_all("run", cyc);
         if (cyc < 800 && d_hs == 1'b0) hs_low_line0++;
         if (cyc < 1600 && d_act) act_two_lines++;
         if (d_ls) def_line_starts++;
         if (cyc < 84 && a_vs) a_vs_frame0++;
         if (b_tick) b_ticks++;
         if (a_fs) begin
            if (a_last_fs >= 0) check("div1_frame_period", 32'(cyc - a_last_fs), 32'd84);
            a_last_fs = cyc;
            a_frames++;
         end
         if (b_fs) begin
            if (b_last_fs >= 0) check("div2_frame_period", 32'(cyc - b_last_fs), 32'd168);
            b_last_fs = cyc;
            b_frames++;
         end
         @(negedge Clk);
      end

      check("def_hsync_low_per_line", 32'(hs_low_line0), 32'd96);
      check("def_active_two_lines", 32'(act_two_lines), 32'd1280);
      check("def_line_starts", 32'(def_line_starts), 32'd3);
      check("div1_vsync_per_frame", 32'(a_vs_frame0), 32'd12);
      check("div1_frame_count", 32'(a_frames), 32'd23);
      check("div2_frame_count", 32'(b_frames), 32'd12);
      check("div2_tick_count", 32'(b_ticks), 32'd951);

      // Mid-frame asynchronous reset between edges, during a non-tick clock.
      check_all("prereset", 1901);
      #2 Reset = 1'b1;
      #1 check_all("async_reset", 0);
      @(negedge Clk);
      check_all("held_reset", 0);

      Reset = 1'b0;
      #1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         check_all("restart", cyc);
         @(negedge Clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
